mem_arbiter: RTL

Two-port arbiter and sequencer for the mini CPU's single-port RAM. It shares the RAM between the control-unit memory path (port 0: MAR/MDR Read/Write) and the I/O DMA path (port 1). It accepts one transaction at a time, drives the RAM strobes for exactly one cycle, waits out the fixed RAM read latency, and returns a one-cycle completion pulse with registered read data to the granted port.

---
 rtl/mini_cpu_pkg.sv | 16 +
 rtl/mem_arb_wait_ctr.sv | 26 ++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared mini-CPU definitions: arbiter FSM states, port indices, default RAM latency.
package mini_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// 3-bit loadable down-counter used to time out the RAM read latency.
// Ports: clk, rst (async, active-high), load/load_val, en (decrement), at_one (count == 1).
module mem_arb_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] load_val,
  output logic       at_one
);

  logic [2:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 3'd1;
    end
  end

  assign at_one = (count == 3'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port RAM (port 0 = CPU, port 1 = DMA).
// Ports: clk, rst (async, active-high); per port req/we/addr/wdata in, gnt/done out;
// rdata (registered read data); mem_addr/mem_wdata/mem_re/mem_we/mem_rdata to the RAM.
// Option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module mem_arbiter
  import mini_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_M1   = 3'(MEM_LAT - 1);
  localparam logic       SHORT_RD = (MEM_LAT == 1);

  arb_state_t          state_q, state_d;
  logic                port_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_any;
  logic                win;
  logic                ctr_load;
  logic                ctr_en;
  logic                ctr_at_one;

  assign req_any = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = req0 ? PORT_CPU : PORT_DMA;
  end
`else
  logic last_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = PORT_DMA;
    end else begin
      win = PORT_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && req_any) begin
      last_q <= win;
    end
  end
`endif

  mem_arb_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (LAT_M1),
    .at_one   (ctr_at_one)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (we_q || SHORT_RD) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_WAIT;
          ctr_load = 1'b1;
        end
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        if (ctr_at_one) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction latches and read-data capture; rdata keys on state_d so the
  // sample lands on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && req_any) begin
        port_q  <= win;
        we_q    <= win ? we1 : we0;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE) && !we_q) begin
        rdata <= mem_rdata;
      end
    end
  end

  // Output logic
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q != ST_IDLE) begin
      gnt0 = (port_q == PORT_CPU);
      gnt1 = (port_q == PORT_DMA);
    end
    if (state_q == ST_ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_re    = ~we_q;
      mem_we    = we_q;
    end
    if (state_q == ST_DONE) begin
      done0 = (port_q == PORT_CPU);
      done1 = (port_q == PORT_DMA);
    end
  end

endmodule
